// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the 32-bit UART link.
// Imported by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 32;
  localparam int CLKS_PER_BIT_DEF = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx32.sv
// 32-bit UART receiver: 1 start, 32 data LSB first, 1 stop.
// Mid-bit sampling; one-cycle rx_valid / frame_err strobes.
module uart_rx32
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  output logic [31:0] data_out,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int DW = UART_DATA_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] H =
    CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_IDX = 5'(DW - 1);

  logic rx_s;

  rx_state_t     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    idx, idx_n;
  logic [DW-1:0] sh, sh_n;
  logic          load;
  logic          vld_n;
  logic          ferr_n;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_in),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      rx_valid  <= vld_n;
      frame_err <= ferr_n;
      if (load) data_out <= sh;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    idx_n  = idx;
    sh_n   = sh;
    load   = 1'b0;
    vld_n  = 1'b0;
    ferr_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (!rx_s) begin
          cnt_n = '0;
          st_n  = START;
        end
      end
      START: begin
        if (cnt == H) begin
          if (!rx_s) begin
            cnt_n = '0;
            idx_n = '0;
            st_n  = DATA;
          end else begin
            st_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[DW-1:1]};
          if (idx == LAST_IDX) st_n = STOP;
          else idx_n = idx + 5'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          // return at mid-stop so a zero-gap start edge is caught
          if (rx_s) begin
            load  = 1'b1;
            vld_n = 1'b1;
            st_n  = IDLE;
          end else begin
            ferr_n = 1'b1;
            st_n   = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign rx_busy = (st != IDLE);

endmodule

// File: tb/tb_uart_rx32.sv
// Scoreboard bench for uart_rx32 at CLKS_PER_BIT=16.
// A serial driver pushes expected words; a monitor pops them.
module tb_uart_rx32;

  localparam int CPB = 16;
  localparam int HH = (CPB - 1) / 2;
  localparam int LAT = 4 + HH + 33 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [31:0] data_out;
  logic        rx_valid;
  logic        frame_err;
  logic        rx_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          exp_ferr = 0;
  int          got_ferr = 0;
  int          n_valid = 0;
  logic [31:0] last_good = '0;
  longint      cyc = 0;
  longint      valid_cyc = 0;
  int          busy_seen;

  uart_rx32 #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && frame_err)
        check("valid_and_ferr", 1, 0);
      if (rx_valid) begin
        n_valid++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", data_out, 0);
        end else begin
          check("rx_word", data_out, exp_q.pop_front());
        end
      end
      if (frame_err) got_ferr++;
    end
  end

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Behavioural transmitter: frame = start, 32 LSB-first, stop.
  task automatic send(input logic [31:0] w,
                      input logic stop_bit);
    logic [33:0] fr;
    fr = {stop_bit, w, 1'b0};
    if (stop_bit) begin
      exp_q.push_back(w);
      last_good = w;
    end else begin
      exp_ferr++;
    end
    for (int b = 0; b < 34; b++) begin
      @(negedge clk);
      rx_in = fr[b];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * CPB) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: pending %0d expected 0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    longint c0;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle(2 * CPB);

    // Frame with latency measurement
    @(negedge clk);
    c0 = cyc;
    n_valid = 0;
    send(32'hDEADBEEF, 1'b1);
    drain("deadbeef");
    idle(2 * CPB);
    check("deadbeef_count", n_valid, 1);
    n_cmp++;
    if (valid_cyc - c0 < LAT - 1 ||
        valid_cyc - c0 > LAT + 1) begin
      n_bad++;
      $display("FAIL latency: got %0d expected %0d",
               valid_cyc - c0, LAT);
    end
    check("data_held", data_out, 32'hDEADBEEF);

    // Start-bit glitch
    n_valid = 0;
    busy_seen = 0;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", rx_busy, 0);
    check("glitch_no_valid", n_valid, 0);
    check("glitch_data", data_out, last_good);

    // Framing error, low hold, then recovery
    n_valid = 0;
    send(32'h12345678, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_data_held", data_out, 32'hDEADBEEF);
    check("ferr_no_valid", n_valid, 0);
    check("ferr_busy_low", rx_busy, 1);
    idle(CPB);
    check("ferr_idle", rx_busy, 0);
    check("ferr_count", got_ferr, exp_ferr);
    send(32'h0000FFFF, 1'b1);
    drain("ffff");
    idle(2 * CPB);
    check("ffff_data", data_out, 32'h0000FFFF);

    // Back-to-back, zero idle gap
    n_valid = 0;
    send(32'h00000001, 1'b1);
    send(32'h80000000, 1'b1);
    drain("b2b");
    idle(2 * CPB);
    check("b2b_count", n_valid, 2);

    // Reset during data bit 10
    @(negedge clk);
    rx_in = 1'b0;
    repeat (CPB * 11 + CPB / 2) @(negedge clk);
    rx_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", data_out, 0);
    check("arst_valid", rx_valid, 0);
    check("arst_ferr", frame_err, 0);
    check("arst_busy", rx_busy, 0);
    last_good = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    send(32'hA5A5A5A5, 1'b1);
    drain("a5");
    idle(2 * CPB);
    check("a5_data", data_out, 32'hA5A5A5A5);

    // Random loopback
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      send(w, 1'b1);
      idle($urandom_range(0, 20));
    end
    drain("loop");
    idle(2 * CPB);
    check("loop_ferr", got_ferr, exp_ferr);
    check("final_data", data_out, last_good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
